hier_inst_scheduler: RTL
========================

Name: hier_inst_scheduler

Overview:
- Round-robin scheduler that shares one resource (configuration/scan/debug access) among the NUM_INST child instances of one hierarchy level; each level of the generated tree has 10 children.
- One instance sits beside each generated parent module.
- Grants go to one child at a time, are held until the child releases or a hold limit expires, and are rotated fairly with wrap-around.

Parameters:
- NUM_INST, 10, number of child instances (requesters), >=2
- ID_W, 4, width of gnt_id, >= clog2(NUM_INST)
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay asserted, >=1
- CNT_W, 16, width of the grant_cnt statistics counter

Ports:
- clk  input  1  clock; all logic rising-edge
- rst  input  1  synchronous active-high reset
- en  input  1  enables issuing new grants
- req  input  NUM_INST  level request per child; bit i = inst_i
- gnt  output  NUM_INST  one-hot grant, registered
- gnt_valid  output  1  OR of gnt
- gnt_id  output  ID_W  index of current owner; holds last owner when gnt_valid=0
- timeout  output  1  one-cycle pulse on forced release
- grant_cnt  output  CNT_W  total grants issued, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge) applies regardless of state, including mid-grant. Next cycle: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, grant_cnt=0, ptr=0, hold_cnt=0.
- All outputs are registered. There is no combinational path from req to gnt.
- FSM states: IDLE, GRANT.
- IDLE, arbitration:
  - Arbitrates when en=1 and |req.
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ..., NUM_INST-1, 0, ..., ptr-1.
  - At the next edge: gnt=1<<winner, gnt_id=winner, hold_cnt=1, grant_cnt+1, state -> GRANT.
  - Latency: req sampled at edge T gives gnt high from cycle T+1.
- IDLE with en=0 or req=0: remain in IDLE with gnt=0.
- GRANT, normal release:
  - Condition: req[gnt_id]=0 at an edge.
  - Next cycle: gnt=0, ptr=(gnt_id+1) mod NUM_INST, state -> IDLE.
- GRANT, forced release:
  - Condition: req[gnt_id]=1 and hold_cnt==MAX_HOLD at an edge.
  - Next cycle: gnt=0, timeout=1 for exactly one cycle, ptr advances as for normal release, state -> IDLE.
  - gnt is never high for more than MAX_HOLD consecutive cycles.
- GRANT, otherwise: hold_cnt+1, gnt unchanged.
- Changes to non-owner req bits are ignored during GRANT. The owner is not preempted.
- Between any two grants, gnt=0 for exactly one cycle (the IDLE cycle), including a re-grant to the same child.
- ptr wraps from NUM_INST-1 to 0. A child released by timeout keeps requesting and gets lowest priority next round.
- en=0 during GRANT: the current grant completes normally (release or timeout). No new grant is issued until en=1.
- grant_cnt wraps silently at 2^CNT_W-1 -> 0.
- Arbitration and release are single-edge decisions. Simultaneous req rise/fall on other bits during release do not affect the outgoing release. They are evaluated in the following IDLE cycle.

Test Plan:
- Single request: reset, en=1; req[3] high from edge 0, dropped at edge 5 -> gnt=0x008, gnt_id=3 cycles 1-5; gnt=0 cycle 6; grant_cnt=1; timeout never pulses.
- Round-robin fairness: req=0x3FF held; each owner drops its bit 2 cycles after its grant and re-raises it 1 cycle later -> gnt_id sequence 0,1,...,9,0,1; exactly one gnt=0 cycle between grants; grant_cnt=12.
- Wrap-around: after grant/release of child 8 (ptr=9), assert req=0x201 -> gnt_id=9 first, then 0 after 9 releases; ptr ends at 1.
- Timeout: MAX_HOLD=16, req[5] held 40 cycles, no other requests -> gnt=0x020 for exactly 16 cycles, timeout=1 for one cycle during the gap, re-grant to 5 next cycle; second timeout after another 16 cycles.
- Enable gating: grant to child 2 active, en dropped, req=0x0F0 pending -> child 2 keeps gnt until it drops req; no further grant while en=0; en=1 -> gnt_id=4 one cycle later.
- Reset mid-grant: rst=1 at cycle 7 of a grant to child 6 -> next cycle gnt=0, gnt_valid=0, gnt_id=0, grant_cnt=0, timeout=0; rst=0 with req[6] high -> gnt_id=6 one cycle after the first arbitration edge.

Source files
------------

// File: rtl/hier_inst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hier_inst_scheduler
//  Brief    : Round-robin owner scheduler for the children of one tree level;
//             grants are held until release or a hold limit forces them off.
//  Revision : 1.0 - initial release
// ============================================================================
module hier_inst_scheduler #(
    parameter int NUM_INST = 10,
    parameter int ID_W     = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_INST-1:0] req,
    output logic [NUM_INST-1:0] gnt,
    output logic                gnt_valid,
    output logic [ID_W-1:0]     gnt_id,
    output logic                timeout,
    output logic [CNT_W-1:0]    grant_cnt
);

    localparam int         c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_GRANT  = 1'b1;

    logic [0:0]          r_state;
    logic [NUM_INST-1:0] r_gnt;
    logic                r_gnt_valid;
    logic [ID_W-1:0]     r_gnt_id;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_grant_cnt;
    logic [ID_W-1:0]     r_ptr;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic [0:0]            w_state_nxt;
    logic [NUM_INST-1:0]   w_gnt_nxt;
    logic [ID_W-1:0]       w_gnt_id_nxt;
    logic                  w_timeout_nxt;
    logic [CNT_W-1:0]      w_grant_cnt_nxt;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;

    logic [2*NUM_INST-1:0] w_req_dbl;
    logic [NUM_INST-1:0]   w_rot;
    logic [ID_W-1:0]       w_off;
    logic [ID_W:0]         w_sum;
    logic [ID_W-1:0]       w_win;
    logic [ID_W-1:0]       w_ptr_adv;
    logic                  w_owner_req;

    // Rotate requests so bit k is child (ptr+k) mod NUM_INST; lowest set bit wins.
    assign w_req_dbl = {req, req} >> r_ptr;
    assign w_rot     = w_req_dbl[NUM_INST-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NUM_INST - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
    end

    assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win       = (w_sum >= (ID_W+1)'(NUM_INST)) ? ID_W'(w_sum - (ID_W+1)'(NUM_INST))
                                                        : w_sum[ID_W-1:0];
    assign w_ptr_adv   = (r_gnt_id == ID_W'(NUM_INST - 1)) ? '0 : r_gnt_id + ID_W'(1);
    assign w_owner_req = |(req & r_gnt);

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_timeout_nxt   = 1'b0;
        w_grant_cnt_nxt = r_grant_cnt;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        case (r_state)
            c_IDLE: begin
                w_gnt_nxt = '0;
                if (en && (|req)) begin
                    w_gnt_nxt       = NUM_INST'(1) << w_win;
                    w_gnt_id_nxt    = w_win;
                    w_hold_nxt      = c_HOLD_W'(1);
                    w_grant_cnt_nxt = r_grant_cnt + CNT_W'(1);
                    w_state_nxt     = c_GRANT;
                end
            end
            default: begin
                // The pointer moves past the owner on either kind of release.
                if (!w_owner_req || (r_hold_cnt == c_HOLD_W'(MAX_HOLD))) begin
                    w_gnt_nxt     = '0;
                    w_timeout_nxt = w_owner_req;
                    w_ptr_nxt     = w_ptr_adv;
                    w_hold_nxt    = '0;
                    w_state_nxt   = c_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_timeout   <= 1'b0;
            r_grant_cnt <= '0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_timeout   <= w_timeout_nxt;
            r_grant_cnt <= w_grant_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign timeout   = r_timeout;
    assign grant_cnt = r_grant_cnt;

endmodule
`default_nettype wire
